// File: rtl/dpwm_sequencer.sv
// -----------------------------------------------------------------------------
// dpwm_sequencer
//
// Sequences and configures a DPWM core. Configuration (duty target, period,
// deadtimes) is captured into shadow registers through a valid/ready handshake
// and applied to the core only at PWM period boundaries, or immediately when
// the core is disabled (IDLE / FAULT). The duty cycle is soft-started from 0
// up to the target, one step per period, before settling in RUN.
//
// Ports
//   hf_clock      system clock, shared with the DPWM core
//   reset         synchronous active-low reset
//   start         level, honoured in IDLE
//   stop          level, honoured in SOFT_START / RUN (acts at next wrap)
//   fault         level, highest priority shutdown
//   fault_clr     level, leaves FAULT when fault is low
//   cfg_valid     new configuration offered
//   cfg_ready     configuration can be accepted (low while one is pending)
//   cfg_duty      target duty cycle
//   cfg_fs        period in hf_clock cycles
//   cfg_dt1/2     deadtimes
//   ramp_step     soft-start increment per period (0 treated as 1)
//   duty_cycle    to DPWM
//   fs            to DPWM (unclamped applied period)
//   deadtime1/2   to DPWM
//   enable        to DPWM
//   period_start  one-cycle pulse at each period start
//   state         IDLE=0, SOFT_START=1, RUN=2, FAULT=3
// -----------------------------------------------------------------------------
module dpwm_sequencer #(
  parameter int FREQ   = 8,
  parameter int DC     = 8,
  parameter int DT     = 8,
  parameter int STEP_W = 4
) (
  input  logic              hf_clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              fault,
  input  logic              fault_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DC-1:0]     cfg_duty,
  input  logic [FREQ-1:0]   cfg_fs,
  input  logic [DT-1:0]     cfg_dt1,
  input  logic [DT-1:0]     cfg_dt2,
  input  logic [STEP_W-1:0] ramp_step,
  output logic [DC-1:0]     duty_cycle,
  output logic [FREQ-1:0]   fs,
  output logic [DT-1:0]     deadtime1,
  output logic [DT-1:0]     deadtime2,
  output logic              enable,
  output logic              period_start,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SOFT  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic [DC-1:0]     duty_q, duty_d;
  logic [FREQ-1:0]   fs_q, fs_d;
  logic [DT-1:0]     dt1_q, dt1_d;
  logic [DT-1:0]     dt2_q, dt2_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              pstart_q, pstart_d;
  logic [FREQ-1:0]   cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [DC-1:0]     target_q, target_d;
  logic              stop_req_q, stop_req_d;
  logic [DC-1:0]     sh_duty_q, sh_duty_d;
  logic [FREQ-1:0]   sh_fs_q, sh_fs_d;
  logic [DT-1:0]     sh_dt1_q, sh_dt1_d;
  logic [DT-1:0]     sh_dt2_q, sh_dt2_d;

  logic [FREQ-1:0]   fs_eff_s;
  logic              wrap_s;
  logic              xfer_s;
  logic              apply_s;
  logic              stop_now_s;
  logic [STEP_W-1:0] step_eff_s;
  logic [DC:0]       sum_s;

  // Next-state logic: handshake, apply, period counter and sequencing FSM.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    duty_d      = duty_q;
    fs_d        = fs_q;
    dt1_d       = dt1_q;
    dt2_d       = dt2_q;
    cfg_ready_d = cfg_ready_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    target_d    = target_q;
    stop_req_d  = stop_req_q;
    sh_duty_d   = sh_duty_q;
    sh_fs_d     = sh_fs_q;
    sh_dt1_d    = sh_dt1_q;
    sh_dt2_d    = sh_dt2_q;

    // Periods shorter than 2 cycles are stretched to 2 internally only.
    if (fs_q < FREQ'(2)) begin
      fs_eff_s = FREQ'(2);
    end else begin
      fs_eff_s = fs_q;
    end
    wrap_s = enable_q && (cnt_q == (fs_eff_s - FREQ'(1)));

    if (ramp_step == STEP_W'(0)) begin
      step_eff_s = STEP_W'(1);
    end else begin
      step_eff_s = ramp_step;
    end
    // One extra bit so duty + step can never roll over before the clamp.
    sum_s = {1'b0, duty_q} + (DC+1)'(step_eff_s);

    stop_now_s = stop_req_q || stop;

    // Capture: cfg_ready is low whenever a config is pending.
    xfer_s = cfg_valid && cfg_ready_q;
    if (xfer_s) begin
      sh_duty_d   = cfg_duty;
      sh_fs_d     = cfg_fs;
      sh_dt1_d    = cfg_dt1;
      sh_dt2_d    = cfg_dt2;
      pending_d   = 1'b1;
      cfg_ready_d = 1'b0;
    end else begin
      sh_duty_d   = sh_duty_q;
    end

    // Apply immediately while the core is off, else only on a period wrap.
    // A fault suppresses the wrap; the pending config then lands in FAULT.
    apply_s = pending_q &&
              ((state_q == S_IDLE) || (state_q == S_FAULT) || (wrap_s && !fault));
    if (apply_s) begin
      fs_d        = sh_fs_q;
      dt1_d       = sh_dt1_q;
      dt2_d       = sh_dt2_q;
      target_d    = sh_duty_q;
      pending_d   = 1'b0;
      cfg_ready_d = 1'b1;
    end else begin
      target_d    = target_q;
    end

    if (enable_q) begin
      if (wrap_s) begin
        cnt_d = FREQ'(0);
      end else begin
        cnt_d = cnt_q + FREQ'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (fault) begin
      state_d    = S_FAULT;
      enable_d   = 1'b0;
      duty_d     = DC'(0);
      cnt_d      = FREQ'(0);
      stop_req_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_SOFT;
            enable_d = 1'b1;
            cnt_d    = FREQ'(0);
            duty_d   = DC'(0);
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_SOFT, S_RUN: begin
          if (stop) begin
            stop_req_d = 1'b1;
          end else begin
            stop_req_d = stop_req_q;
          end
          if (wrap_s && stop_now_s) begin
            state_d    = S_IDLE;
            enable_d   = 1'b0;
            duty_d     = DC'(0);
            cnt_d      = FREQ'(0);
            stop_req_d = 1'b0;
          end else if (wrap_s && (state_q == S_SOFT)) begin
            // Also covers a target lowered below the current duty.
            if (sum_s >= {1'b0, target_d}) begin
              duty_d  = target_d;
              state_d = S_RUN;
            end else begin
              duty_d  = sum_s[DC-1:0];
            end
          end else if (wrap_s) begin
            duty_d = target_d;
          end else begin
            duty_d = duty_q;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FAULT;
          end
        end
        default: begin
          state_d  = S_IDLE;
          enable_d = 1'b0;
          duty_d   = DC'(0);
          cnt_d    = FREQ'(0);
        end
      endcase
    end

    pstart_d = enable_d && (cnt_d == FREQ'(0));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge hf_clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      enable_q    <= 1'b0;
      duty_q      <= DC'(0);
      fs_q        <= {FREQ{1'b1}};
      dt1_q       <= DT'(0);
      dt2_q       <= DT'(0);
      cfg_ready_q <= 1'b1;
      pstart_q    <= 1'b0;
      cnt_q       <= FREQ'(0);
      pending_q   <= 1'b0;
      target_q    <= DC'(0);
      stop_req_q  <= 1'b0;
      sh_duty_q   <= DC'(0);
      sh_fs_q     <= FREQ'(0);
      sh_dt1_q    <= DT'(0);
      sh_dt2_q    <= DT'(0);
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      duty_q      <= duty_d;
      fs_q        <= fs_d;
      dt1_q       <= dt1_d;
      dt2_q       <= dt2_d;
      cfg_ready_q <= cfg_ready_d;
      pstart_q    <= pstart_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      target_q    <= target_d;
      stop_req_q  <= stop_req_d;
      sh_duty_q   <= sh_duty_d;
      sh_fs_q     <= sh_fs_d;
      sh_dt1_q    <= sh_dt1_d;
      sh_dt2_q    <= sh_dt2_d;
    end
  end

  assign state        = state_q;
  assign enable       = enable_q;
  assign duty_cycle   = duty_q;
  assign fs           = fs_q;
  assign deadtime1    = dt1_q;
  assign deadtime2    = dt2_q;
  assign cfg_ready    = cfg_ready_q;
  assign period_start = pstart_q;

endmodule
